lvt_write_scheduler: RTL
========================

Name: lvt_write_scheduler

Overview:
Write-side scheduler for a live-value-table (LVT) two-write-port memory built from two RAM banks plus a per-address flag array that records which bank last wrote each address. It accepts write requests from NUM_REQ requesters, grants up to two per cycle round-robin, and drives write port A and write port B. Same-address pairs are never issued in one cycle. After reset it can sweep every address through port A, so all flags point to bank A with zeroed data.

Parameters:
ADDR_WIDTH, 4, address width; NUM_SLOTS = 2^ADDR_WIDTH
DATA_WIDTH, 16, write data width
NUM_REQ, 4, number of requesters (2..8)

Ports:
clk  in  1  clock; all logic on posedge
rst_n  in  1  synchronous reset, active low
req_valid  in  NUM_REQ  request i pending
req_addr  in  NUM_REQ*ADDR_WIDTH  address of request i, slice i
req_data  in  NUM_REQ*DATA_WIDTH  data of request i, slice i
req_ready  out  NUM_REQ  grant; transfer when req_valid[i] && req_ready[i]
we_a  out  1  port A write enable (registered)
waddr_a  out  ADDR_WIDTH  port A address (registered)
wdata_a  out  DATA_WIDTH  port A data (registered)
we_b  out  1  port B write enable (registered)
waddr_b  out  ADDR_WIDTH  port B address (registered)
wdata_b  out  DATA_WIDTH  port B data (registered)
init_busy  out  1  high during init sweep

Behaviour:
- Reset (rst_n=0 at clk edge, any state): state<=INIT, sweep counter<=0, rr pointer<=0, we_a=we_b=0, waddr/wdata=0, init_busy=1. This also applies to a reset mid-sweep or mid-traffic; an in-flight registered write is dropped.
- States: INIT, RUN.
- INIT: each cycle issue we_a=1, waddr_a=counter, wdata_a=0; we_b=0; req_ready=0. Counter increments. After issuing address NUM_SLOTS-1, go to RUN. The sweep takes exactly NUM_SLOTS cycles; init_busy falls in the cycle after the last sweep write is registered.
- RUN, grant selection (combinational from req_valid, req_addr and rr pointer):
  - First winner W0 = first valid index scanning ptr, ptr+1, ... (mod NUM_REQ) -> port A.
  - Second winner W1 = next valid index after W0 in the same scan whose address != address of W0 -> port B.
  - Valid requests with address equal to W0's are skipped this cycle and stay pending.
  - req_ready[i]=1 only for W0 and W1. Ready may depend on valid; requesters must not make valid depend on ready.
- Latency: a grant in cycle t produces we_x=1 with that addr/data in cycle t+1. With no grant, we_x=0 in cycle t+1 and addr/data hold their previous values.
- Pointer: after any grant, ptr <= (last granted index + 1) mod NUM_REQ. With no grant, ptr holds.
- Throughput: 2 writes/cycle when two or more distinct-address requests are pending.
- Port B wins contests at the flag array. The scheduler never issues equal waddr_a/waddr_b with both enables high, so bank selection is unambiguous.
- No requester is starved: every valid request is granted within NUM_REQ cycles when it is the scan head.
- NUM_REQ wraps mod NUM_REQ; the sweep counter width is ADDR_WIDTH+1 to detect the end without overflow.

Optional Feature:
Macro LVT_SCHED_INIT_EN.
- Defined: INIT sweep as above after every reset.
- Undefined: reset enters RUN directly; init_busy tied 0; no sweep logic or counter is built. Flag and bank contents are undefined until written.

Test Plan:
1. Release rst_n with ADDR_WIDTH=4 and the macro defined -> exactly 16 cycles of we_a=1, waddr_a 0..15, wdata_a=0, we_b=0, req_ready=0; init_busy then falls and RUN begins.
2. RUN with ptr=0; req 0 (addr 3, 0x1111) and req 2 (addr 7, 0x2222) valid -> ready=0b0101; next cycle we_a addr 3/0x1111, we_b addr 7/0x2222; ptr=3.
3. RUN; req 1 and req 3 both addr 5, ptr=0 -> ready=0b0010 only, port A writes addr 5; next cycle req 3 granted on port A; no cycle has both ports on addr 5.
4. All 4 requesters continuously valid with distinct addresses -> grant pairs (0,1),(2,3),(0,1)...; every requester is served once per 2 cycles.
5. Assert rst_n=0 for one cycle mid-sweep (counter=9) -> next cycle we_a=0; the sweep restarts from address 0 and takes 16 full cycles.
6. Macro undefined; release reset with req 1 valid (addr 2) -> req_ready[1]=1 in the first cycle, init_busy=0 throughout, we_a addr 2 one cycle later.

Source files
------------

// File: rtl/lvt_write_scheduler_if.sv
// Request and write-port bundle for the LVT write scheduler.
// The master side raises requests and observes the two bank write ports.
interface lvt_write_scheduler_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 16,
  parameter int NUM_REQ    = 4
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          we_a;
  logic [ADDR_WIDTH-1:0]         waddr_a;
  logic [DATA_WIDTH-1:0]         wdata_a;
  logic                          we_b;
  logic [ADDR_WIDTH-1:0]         waddr_b;
  logic [DATA_WIDTH-1:0]         wdata_b;
  logic                          init_busy;

  modport master (
    output req_valid, req_addr, req_data,
    input  req_ready, we_a, waddr_a, wdata_a, we_b, waddr_b, wdata_b, init_busy
  );

  modport slave (
    input  req_valid, req_addr, req_data,
    output req_ready, we_a, waddr_a, wdata_a, we_b, waddr_b, wdata_b, init_busy
  );
endinterface

// File: rtl/lvt_write_scheduler.sv
// Two-port write scheduler for a live-value-table memory: grants up to two distinct-address
// requests per cycle round-robin. LVT_SCHED_INIT_EN adds a post-reset zeroing sweep on port A.
module lvt_write_scheduler #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 16,
  parameter int NUM_REQ    = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  lvt_write_scheduler_if.slave bus
);
  localparam int IDX_W = $clog2(NUM_REQ);
  typedef logic [IDX_W-1:0] idx_t;

  function automatic idx_t wrap_idx(input idx_t base, input int unsigned off);
    int unsigned sum_v;
    sum_v = 32'(base) + off;
    if (sum_v >= unsigned'(NUM_REQ)) begin
      sum_v = sum_v - unsigned'(NUM_REQ);
    end else begin
      sum_v = sum_v;
    end
    return idx_t'(sum_v);
  endfunction

  logic [ADDR_WIDTH-1:0] addr_s [NUM_REQ];
  logic [DATA_WIDTH-1:0] data_s [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign addr_s[g] = bus.req_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign data_s[g] = bus.req_data[g*DATA_WIDTH +: DATA_WIDTH];
  end

  logic                  run_s;
  logic                  sweep_s;
  logic [ADDR_WIDTH-1:0] sweep_addr_s;
  logic                  grant_en_s;

`ifdef LVT_SCHED_INIT_EN
  localparam int NUM_SLOTS = 1 << ADDR_WIDTH;
  localparam int CNT_W     = ADDR_WIDTH + 1;
  localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(NUM_SLOTS - 1);

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t           state_r, state_next_s;
  logic [CNT_W-1:0] sweep_cnt_r, sweep_cnt_next_s;
  logic             init_busy_r;

  // sweep/run state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= ST_INIT;
      sweep_cnt_r <= {CNT_W{1'b0}};
      init_busy_r <= 1'b1;
    end else begin
      state_r     <= state_next_s;
      sweep_cnt_r <= sweep_cnt_next_s;
      init_busy_r <= (state_next_s == ST_INIT);
    end
  end

  // sweep advance; leave INIT once the last slot has been issued
  always_comb begin
    state_next_s     = state_r;
    sweep_cnt_next_s = sweep_cnt_r;
    case (state_r)
      ST_INIT: begin
        sweep_cnt_next_s = sweep_cnt_r + CNT_W'(1);
        if (sweep_cnt_r == LAST_SLOT) begin
          state_next_s = ST_RUN;
        end else begin
          state_next_s = ST_INIT;
        end
      end
      ST_RUN:  state_next_s = ST_RUN;
      default: state_next_s = ST_INIT;
    endcase
  end

  assign run_s         = (state_r == ST_RUN);
  assign sweep_s       = (state_r == ST_INIT);
  assign sweep_addr_s  = sweep_cnt_r[ADDR_WIDTH-1:0];
  assign bus.init_busy = init_busy_r;
`else
  assign run_s         = 1'b1;
  assign sweep_s       = 1'b0;
  assign sweep_addr_s  = {ADDR_WIDTH{1'b0}};
  assign bus.init_busy = 1'b0;
`endif

  // Grants are suppressed while reset is asserted so no transfer is acknowledged and then dropped.
  assign grant_en_s = rst_n & run_s;

  idx_t               ptr_r, ptr_next_s, last_idx_s;
  idx_t               cand_s, w0_idx_s, w1_idx_s;
  logic               w0_found_s, w1_found_s, take_w0_s, take_w1_s;
  logic [NUM_REQ-1:0] ready_s;

  // round-robin scan from ptr: first valid -> port A, next valid with a different address -> port B
  always_comb begin
    w0_found_s = 1'b0;
    w1_found_s = 1'b0;
    w0_idx_s   = {IDX_W{1'b0}};
    w1_idx_s   = {IDX_W{1'b0}};
    cand_s     = {IDX_W{1'b0}};
    take_w0_s  = 1'b0;
    take_w1_s  = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand_s     = wrap_idx(ptr_r, unsigned'(k));
      take_w0_s  = grant_en_s && bus.req_valid[cand_s] && !w0_found_s;
      take_w1_s  = grant_en_s && bus.req_valid[cand_s] && w0_found_s && !w1_found_s
                   && (addr_s[cand_s] != addr_s[w0_idx_s]);
      w0_idx_s   = take_w0_s ? cand_s : w0_idx_s;
      w1_idx_s   = take_w1_s ? cand_s : w1_idx_s;
      w0_found_s = w0_found_s | take_w0_s;
      w1_found_s = w1_found_s | take_w1_s;
    end
  end

  // ready one-hot per winner, and pointer advance past the last granted index
  always_comb begin
    ready_s             = {NUM_REQ{1'b0}};
    ready_s[w0_idx_s]   = ready_s[w0_idx_s] | w0_found_s;
    ready_s[w1_idx_s]   = ready_s[w1_idx_s] | w1_found_s;
    last_idx_s          = w1_found_s ? w1_idx_s : w0_idx_s;
    ptr_next_s          = w0_found_s ? wrap_idx(last_idx_s, 32'd1) : ptr_r;
  end

  assign bus.req_ready = ready_s;

  logic                  we_a_r, we_b_r;
  logic [ADDR_WIDTH-1:0] waddr_a_r, waddr_b_r;
  logic [DATA_WIDTH-1:0] wdata_a_r, wdata_b_r;

  // registered write ports and arbitration pointer; address/data hold when idle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_r     <= {IDX_W{1'b0}};
      we_a_r    <= 1'b0;
      waddr_a_r <= {ADDR_WIDTH{1'b0}};
      wdata_a_r <= {DATA_WIDTH{1'b0}};
      we_b_r    <= 1'b0;
      waddr_b_r <= {ADDR_WIDTH{1'b0}};
      wdata_b_r <= {DATA_WIDTH{1'b0}};
    end else begin
      ptr_r     <= ptr_next_s;
      we_a_r    <= w0_found_s | sweep_s;
      waddr_a_r <= sweep_s ? sweep_addr_s
                           : (w0_found_s ? addr_s[w0_idx_s] : waddr_a_r);
      wdata_a_r <= sweep_s ? {DATA_WIDTH{1'b0}}
                           : (w0_found_s ? data_s[w0_idx_s] : wdata_a_r);
      we_b_r    <= w1_found_s;
      waddr_b_r <= w1_found_s ? addr_s[w1_idx_s] : waddr_b_r;
      wdata_b_r <= w1_found_s ? data_s[w1_idx_s] : wdata_b_r;
    end
  end

  assign bus.we_a    = we_a_r;
  assign bus.waddr_a = waddr_a_r;
  assign bus.wdata_a = wdata_a_r;
  assign bus.we_b    = we_b_r;
  assign bus.waddr_b = waddr_b_r;
  assign bus.wdata_b = wdata_b_r;
endmodule
